// File: rtl/sprite_layer.sv
// rtl/sprite_layer.sv - animated sprite layer: frame-synchronous position update,
// 3-stage ROM pipeline and colour-key transparency.
module sprite_layer #(
  parameter int                 DEPTH    = 4,
  parameter int                 SPR_W    = 16,
  parameter int                 SPR_H    = 16,
  parameter int                 N_FRAMES = 4,
  parameter int                 ANIM_DIV = 8,
  parameter logic [3*DEPTH-1:0] KEY      = 12'hF0F
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [10:0]                              hcount,
  input  logic [10:0]                              vcount,
  input  logic                                     de_in,
  input  logic                                     frame_start,
  input  logic [10:0]                              pos_x,
  input  logic [10:0]                              pos_y,
  input  logic                                     pos_valid,
  input  logic                                     anim_en,
  output logic [$clog2(N_FRAMES*SPR_W*SPR_H)-1:0]  rom_addr,
  input  logic [3*DEPTH-1:0]                       rom_data,
  output logic [DEPTH-1:0]                         R_out,
  output logic [DEPTH-1:0]                         G_out,
  output logic [DEPTH-1:0]                         B_out,
  output logic                                     A_out,
  output logic                                     de_out
);

  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);
  localparam int FW = $clog2(N_FRAMES);
  localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic [10:0]   r_sh_x, r_sh_y, r_act_x, r_act_y;
  logic [DW-1:0] r_div;
  logic [FW-1:0] r_frame;
  logic          r_hit1, r_de1, r_hit2, r_de2;

  logic [11:0]   w_hc, w_vc, w_x0, w_y0, w_x1, w_y1;
  logic          w_hit;
  logic [XW-1:0] w_dx;
  logic [YW-1:0] w_dy;

  // One extra bit keeps act+size from wrapping back onto the left/top edge.
  assign w_hc  = {1'b0, hcount};
  assign w_vc  = {1'b0, vcount};
  assign w_x0  = {1'b0, r_act_x};
  assign w_y0  = {1'b0, r_act_y};
  assign w_x1  = w_x0 + 12'(SPR_W);
  assign w_y1  = w_y0 + 12'(SPR_H);
  assign w_hit = de_in && (w_hc >= w_x0) && (w_hc < w_x1) &&
                 (w_vc >= w_y0) && (w_vc < w_y1);
  assign w_dx  = XW'(hcount - r_act_x);
  assign w_dy  = YW'(vcount - r_act_y);

  // Active position only moves at frame_start so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_x  <= '0;
      r_sh_y  <= '0;
      r_act_x <= '0;
      r_act_y <= '0;
    end else begin
      if (pos_valid) begin
        r_sh_x <= pos_x;
        r_sh_y <= pos_y;
      end
      if (frame_start) begin
        r_act_x <= r_sh_x;
        r_act_y <= r_sh_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= '0;
      r_frame <= '0;
    end else if (frame_start && anim_en) begin
      if (r_div == DW'(ANIM_DIV - 1)) begin
        r_div   <= '0;
        r_frame <= r_frame + FW'(1);
      end else begin
        r_div <= r_div + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      r_hit1   <= 1'b0;
      r_de1    <= 1'b0;
      r_hit2   <= 1'b0;
      r_de2    <= 1'b0;
      R_out    <= '0;
      G_out    <= '0;
      B_out    <= '0;
      A_out    <= 1'b0;
      de_out   <= 1'b0;
    end else begin
      if (w_hit)
        rom_addr <= {r_frame, w_dy, w_dx};
      r_hit1 <= w_hit;
      r_de1  <= de_in;
      r_hit2 <= r_hit1;
      r_de2  <= r_de1;
      de_out <= r_de2;
      if (r_hit2 && (rom_data != KEY)) begin
        {R_out, G_out, B_out} <= rom_data;
        A_out                 <= 1'b1;
      end else begin
        {R_out, G_out, B_out} <= '0;
        A_out                 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_layer.sv
// tb/tb_sprite_layer.sv - randomized and directed stimulus for sprite_layer,
// compared against a pixel-level behavioural model of the sprite layer.
module tb_sprite_layer;

  localparam int          ANIM_DIV = 8;
  localparam int          N_FRAMES = 4;
  localparam logic [11:0] KEY      = 12'hF0F;

  logic        clk = 1'b0;
  logic        rst, de_in, frame_start, pos_valid, anim_en;
  logic [10:0] hcount, vcount, pos_x, pos_y;
  logic [9:0]  rom_addr;
  logic [11:0] rom_data;
  logic [3:0]  R_out, G_out, B_out;
  logic        A_out, de_out;

  logic [11:0] rom [1024];

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  sprite_layer dut (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .de_in(de_in),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y),
    .pos_valid(pos_valid), .anim_en(anim_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .R_out(R_out), .G_out(G_out), .B_out(B_out),
    .A_out(A_out), .de_out(de_out)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model state: positions, total enabled frame_start pulses since reset.
  int m_sh_x = 0, m_sh_y = 0, m_ax = 0, m_ay = 0, m_pulses = 0, m_addr = 0;
  int exp_a [8192];
  int exp_rgb [8192];
  int exp_de [8192];
  int n_cyc = 0;

  task automatic apply(input int hc, input int vc, input bit de, input bit fs,
                       input bit pv, input int px, input int py, input bit an,
                       input bit r);
    int  idx, word, k;
    bit  hit;
    hcount      = 11'(hc);
    vcount      = 11'(vc);
    de_in       = de;
    frame_start = fs;
    pos_valid   = pv;
    pos_x       = 11'(px);
    pos_y       = 11'(py);
    anim_en     = an;
    rst         = r;

    idx = (m_pulses / ANIM_DIV) % N_FRAMES;
    hit = de && hc >= m_ax && hc < m_ax + 16 && vc >= m_ay && vc < m_ay + 16;
    exp_a[n_cyc]   = 0;
    exp_rgb[n_cyc] = 0;
    exp_de[n_cyc]  = int'(de);
    if (hit) begin
      m_addr = idx * 256 + (vc - m_ay) * 16 + (hc - m_ax);
      word   = int'(rom[m_addr]);
      if (word != int'(KEY)) begin
        exp_a[n_cyc]   = 1;
        exp_rgb[n_cyc] = word;
      end
    end

    if (r) begin
      // Reset discards this pixel and the two already in flight.
      for (int j = 0; j < 3; j++) begin
        if (n_cyc - j >= 0) begin
          exp_a[n_cyc - j]   = 0;
          exp_rgb[n_cyc - j] = 0;
          exp_de[n_cyc - j]  = 0;
        end
      end
      m_addr = 0; m_sh_x = 0; m_sh_y = 0; m_ax = 0; m_ay = 0; m_pulses = 0;
    end else begin
      if (fs) begin
        m_ax = m_sh_x;
        m_ay = m_sh_y;
        if (an) m_pulses++;
      end
      if (pv) begin
        m_sh_x = px;
        m_sh_y = py;
      end
    end

    @(posedge clk);
    #1;
    check("rom_addr", 32'(rom_addr), 32'(m_addr));
    k = n_cyc - 2;
    check("A_out", 32'(A_out), (k >= 0) ? 32'(exp_a[k]) : 32'd0);
    check("RGB_out", 32'({R_out, G_out, B_out}), (k >= 0) ? 32'(exp_rgb[k]) : 32'd0);
    check("de_out", 32'(de_out), (k >= 0) ? 32'(exp_de[k]) : 32'd0);
    n_cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic scan(input int vc, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) apply(h, vc, (h < 640 && vc < 480), 0, 0, 0, 0, 0, 0);
    idle(3);
  endtask

  task automatic set_pos(input int px, input int py);
    apply(0, 0, 0, 0, 1, px, py, 0, 0);
    apply(0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int hc, vc, px, py;
    bit de, fs, pv, an, r;

    for (int i = 0; i < 1024; i++) begin
      rom[i] = 12'($urandom);
      if (rom[i] == KEY) rom[i] = 12'h000;
      if ($urandom_range(0, 7) == 0) rom[i] = KEY;
    end
    rom[2] = 12'h123;
    rom[3] = KEY;
    rom[4] = 12'h456;

    for (int i = 0; i < 3; i++) apply(0, 0, 0, 1, 1, 55, 66, 1, 1);

    // Basic placement and a keyed pixel in row 0.
    set_pos(100, 50);
    scan(50, 99, 116);
    scan(51, 98, 117);

    // Mid-frame move is deferred; coincident move waits one more frame.
    apply(0, 0, 0, 0, 1, 200, 200, 0, 0);
    scan(50, 95, 120);
    scan(200, 195, 220);
    apply(0, 0, 0, 1, 0, 0, 0, 0, 0);
    scan(50, 95, 120);
    scan(200, 195, 220);
    apply(0, 0, 0, 1, 1, 300, 100, 0, 0);
    scan(100, 295, 320);
    scan(205, 195, 220);
    apply(0, 0, 0, 1, 0, 0, 0, 0, 0);
    scan(100, 295, 320);

    // Animation stepping, then freeze.
    set_pos(100, 50);
    for (int p = 1; p <= 41; p++) begin
      apply(0, 0, 0, 1, 0, 0, 0, 1, 0);
      apply(100, 50, 1, 0, 0, 0, 0, 0, 0);
      check("anim_base", 32'(rom_addr), 32'(((p / 8) % 4) * 256));
      idle(2);
    end
    for (int p = 0; p < 10; p++) begin
      apply(0, 0, 0, 1, 0, 0, 0, 0, 0);
      apply(100, 50, 1, 0, 0, 0, 0, 0, 0);
      check("anim_frozen", 32'(rom_addr), 32'd256);
      idle(2);
    end

    // Right and bottom screen edges; de_in low inside the box.
    set_pos(630, 470);
    scan(472, 625, 650);
    scan(479, 625, 650);
    scan(482, 625, 650);
    for (int h = 628; h < 640; h++) apply(h, 475, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Reset in the middle of a hit run.
    set_pos(100, 50);
    for (int h = 98; h < 118; h++) apply(h, 52, 1, 0, 0, 0, 0, 0, (h == 106));
    scan(52, 98, 118);
    check("rst_addr_zero", 32'(rom_addr), 32'd0);
    scan(3, 0, 20);

    for (int i = 0; i < 2500; i++) begin
      hc = m_ax + $urandom_range(0, 24) - 4;
      vc = m_ay + $urandom_range(0, 20) - 2;
      if (hc < 0) hc = 0;
      if (vc < 0) vc = 0;
      de = ($urandom_range(0, 7) != 0) && hc < 640 && vc < 480;
      fs = ($urandom_range(0, 39) == 0);
      pv = ($urandom_range(0, 29) == 0);
      px = $urandom_range(0, 700);
      py = $urandom_range(0, 520);
      an = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 499) == 0);
      apply(hc, vc, de, fs, pv, px, py, an, r);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
